serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8, SHALL be the operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL indicate that a, b and sub hold a request.
REQ-005 in_ready  output  1  SHALL indicate that the block accepts a request this cycle.
REQ-006 a  input  WIDTH  SHALL be operand A, unsigned or two's complement.
REQ-007 b  input  WIDTH  SHALL be operand B.
REQ-008 sub  input  1  SHALL select the operation: 0 = A+B, 1 = A-B.
REQ-009 z  output  WIDTH  SHALL be the result.
REQ-010 cout  output  1  SHALL be the final carry out of the MSB (for subtraction, 1 = no borrow).
REQ-011 ovf  output  1  SHALL be the two's-complement signed overflow flag.
REQ-012 out_valid  output  1  SHALL indicate that z, cout and ovf are valid.
REQ-013 out_ready  input  1  SHALL indicate that the consumer takes the result this cycle.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE->RUN SHALL occur on a cycle with in_valid=1 in IDLE (accept edge), with the following effects:
- latch a into shift register SA;
- latch b XOR {WIDTH{sub}} into shift register SB;
- set the carry register C to sub;
- clear the bit counter and the result shift register.
REQ-017 Each RUN cycle SHALL compute one bit LSB-first, using one full adder on SA[0], SB[0] and C:
- shift the sum bit into the result MSB and shift the result right;
- shift SA and SB right;
- C takes the carry out of the full adder;
- increment the counter.
REQ-018 After exactly WIDTH RUN cycles the FSM SHALL go to DONE, so out_valid rises WIDTH+1 cycles after the accept edge.
REQ-019 In DONE, the outputs SHALL be:
- z = the full WIDTH-bit result;
- cout = C;
- ovf = carry into MSB XOR carry out of MSB, captured during the last RUN cycle.
REQ-020 z, cout and ovf SHALL hold stable while out_valid=1 and out_ready=0 (back-pressure, unlimited duration).
REQ-021 DONE->IDLE SHALL occur on a cycle with out_valid=1 and out_ready=1; in_ready SHALL be 1 on the following cycle.
REQ-022 Inputs a, b and sub SHALL be ignored outside the accept edge; changes during RUN or DONE SHALL NOT affect the result.
REQ-023 in_valid asserted in RUN or DONE SHALL NOT be accepted or queued; the requester SHALL hold in_valid until it sees in_ready.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH, and z SHALL equal (a + b) mod 2^WIDTH or (a - b) mod 2^WIDTH.
REQ-025 Throughput SHALL be one operation per WIDTH+2 cycles when out_ready is tied to 1.
REQ-026 z, cout and ovf SHALL be 0 whenever out_valid=0.

Reset
REQ-027 Asserting reset SHALL immediately, without waiting for clk, force the following:
- FSM to IDLE;
- SA, SB, the result register, C, the counter and the ovf register to 0;
- in_ready=1, out_valid=0, z=0, cout=0, ovf=0.
REQ-028 A reset asserted in RUN or DONE SHALL abandon the operation with no result ever presented.
REQ-029 The first accept SHALL be possible on the first rising clk edge after reset deasserts.

Verification
REQ-030 WIDTH=8, a=8'h05, b=8'h03, sub=0, out_ready=1 -> out_valid rises 9 cycles after accept with z=8'h08, cout=0, ovf=0.
REQ-031 a=8'hFF, b=8'h01, sub=0 -> z=8'h00, cout=1, ovf=0; a=8'h7F, b=8'h01, sub=0 -> z=8'h80, cout=0, ovf=1.
REQ-032 a=8'h03, b=8'h05, sub=1 -> z=8'hFE, cout=0 (borrow); a=8'h80, b=8'h01, sub=1 -> z=8'h7F, ovf=1.
REQ-033 Back-pressure: hold out_ready=0 for 5 cycles in DONE while toggling a, b, sub and in_valid -> z, cout and ovf stay constant, in_ready stays 0, and no second request is accepted.
REQ-034 Assert reset 4 cycles after accept, then deassert -> all outputs 0 and in_ready=1 immediately; the next request a=8'h10, b=8'h20, sub=0 yields z=8'h30.
REQ-035 Exhaustive sweep at WIDTH=4 over all a, b and sub with random out_ready -> every z, cout and ovf matches the reference model of REQ-024 and REQ-019.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full adder processes a WIDTH-bit operation LSB-first,
// with a valid/ready handshake on both the request side and the result side.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    // state | meaning
    // IDLE  | waiting for a request, in_ready=1
    // RUN   | one result bit per cycle, WIDTH cycles
    // DONE  | result presented, waits for out_ready

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             ovf_q;

    logic accept;
    logic step;
    logic last_step;
    logic sum_bit;
    logic carry_bit;

    assign accept    = (state_q == IDLE) && in_valid;
    assign step      = (state_q == RUN);
    assign last_step = step && (cnt == LAST);

    assign sum_bit   = sa[0] ^ sb[0] ^ c;
    assign carry_bit = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (cnt == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: invert B on entry and seed the carry with sub.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            sa    <= a;
            sb    <= b ^ {WIDTH{sub}};
            res   <= '0;
            c     <= sub;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else if (step) begin
            sa  <= {1'b0, sa[WIDTH-1:1]};
            sb  <= {1'b0, sb[WIDTH-1:1]};
            res <= {sum_bit, res[WIDTH-1:1]};
            c   <= carry_bit;
            cnt <= cnt + CW'(1);
            if (last_step) begin
                ovf_q <= c ^ carry_bit;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign z         = out_valid ? res : '0;
    assign cout      = out_valid & c;
    assign ovf       = out_valid & ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: reference vectors, latency, back-pressure,
// throughput, mid-operation reset, and an exhaustive 4-bit sweep.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] z;
    logic       cout;
    logic       ovf;
    logic       out_valid;
    logic       out_ready;

    logic       iv4;
    logic       ir4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       sub4;
    logic [3:0] z4;
    logic       cout4;
    logic       ovf4;
    logic       ov4;
    logic       or4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .z(z), .cout(cout), .ovf(ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .sub(sub4), .z(z4), .cout(cout4), .ovf(ovf4),
        .out_valid(ov4), .out_ready(or4)
    );

    // Issues one request on the 8-bit DUT and waits for its result; lat counts
    // clock edges from the accept edge (inclusive) to the first out_valid.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                          input bit release_done, output logic [7:0] rz,
                          output logic rc, output logic ro, output int lat);
        int guard;
        a = ta; b = tb; sub = ts; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ta ^ 8'hA5; b = tb ^ 8'h3C; sub = ~ts;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        rz = z; rc = cout; ro = ovf;
        if (release_done && out_valid) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || z !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b z=%h cout=%b ovf=%b, want 1 0 00 0 0",
                     in_ready, out_valid, z, cout, ovf);
        end
        reset = 1'b0;
    endtask

    task automatic test_vectors();
        logic [7:0] va [6] = '{8'h05, 8'hFF, 8'h7F, 8'h03, 8'h80, 8'h00};
        logic [7:0] vb [6] = '{8'h03, 8'h01, 8'h01, 8'h05, 8'h01, 8'h00};
        logic       vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] ez [6] = '{8'h08, 8'h00, 8'h80, 8'hFE, 8'h7F, 8'h00};
        logic       ec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       eo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] rz;
        logic       rc, ro;
        int         lat;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vs[i], 1'b1, rz, rc, ro, lat);
            tests++;
            if (rz !== ez[i] || rc !== ec[i] || ro !== eo[i]) begin
                fails++;
                $display("FAIL vector%0d: got z=%h cout=%b ovf=%b, want z=%h cout=%b ovf=%b",
                         i, rz, rc, ro, ez[i], ec[i], eo[i]);
            end
            tests++;
            if (lat !== 9) begin
                fails++;
                $display("FAIL latency%0d: got %0d cycles, want 9", i, lat);
            end
            tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || z !== 8'h00) begin
                fails++;
                $display("FAIL return_idle%0d: got in_ready=%b out_valid=%b z=%h, want 1 0 00",
                         i, in_ready, out_valid, z);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] rz;
        logic       rc, ro;
        int         lat;
        out_ready = 1'b0;
        run_op(8'h5A, 8'h33, 1'b0, 1'b0, rz, rc, ro, lat);
        tests++;
        if (rz !== 8'h8D || rc !== 1'b0 || ro !== 1'b1 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_result: got z=%h cout=%b ovf=%b out_valid=%b, want 8d 0 1 1", rz, rc, ro, out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 8'(i * 37 + 1); b = 8'(i * 91 + 7); sub = i[0];
            @(posedge clk); #1;
            tests++;
            if (z !== 8'h8D || cout !== 1'b0 || ovf !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold%0d: got z=%h cout=%b ovf=%b in_ready=%b out_valid=%b, want 8d 0 1 0 1",
                         i, z, cout, ovf, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_no_queue: got in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int acc [3];
        int n = 0;
        int zbad = 0;
        out_ready = 1'b1;
        a = 8'h01; b = 8'h02; sub = 1'b0; in_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
            if (in_ready) begin
                acc[n] = cyc;
                n++;
            end
            if (out_valid && z !== 8'h03) zbad++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests++;
        if (n !== 3 || acc[1] - acc[0] !== 10 || acc[2] - acc[1] !== 10) begin
            fails++;
            $display("FAIL throughput: got %0d accepts, spacing %0d %0d, want 3 accepts spaced 10",
                     n, acc[1] - acc[0], acc[2] - acc[1]);
        end
        tests++;
        if (zbad !== 0) begin
            fails++;
            $display("FAIL b2b_result: got %0d wrong results, want 0", zbad);
        end
        for (int i = 0; i < 20 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midop();
        logic [7:0] rz;
        logic       rc, ro;
        int         lat;
        int         seen = 0;
        out_ready = 1'b1;
        a = 8'h11; b = 8'h22; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || z !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got in_ready=%b out_valid=%b z=%h cout=%b ovf=%b, want 1 0 00 0 0",
                     in_ready, out_valid, z, cout, ovf);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        tests++;
        if (seen !== 0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL abandoned_op: got %0d out_valid cycles in_ready=%b, want 0 and 1", seen, in_ready);
        end
        run_op(8'h10, 8'h20, 1'b0, 1'b1, rz, rc, ro, lat);
        tests++;
        if (rz !== 8'h30 || rc !== 1'b0 || ro !== 1'b0 || lat !== 9) begin
            fails++;
            $display("FAIL after_reset: got z=%h cout=%b ovf=%b lat=%0d, want 30 0 0 9", rz, rc, ro, lat);
        end
    endtask

    task automatic test_exhaustive4();
        logic [3:0] av, bv, bb, ez;
        logic [4:0] full;
        logic       sv, ec, eo;
        logic [3:0] gz;
        logic       gc, go;
        int         guard;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int is = 0; is < 2; is++) begin
                    av = 4'(ia); bv = 4'(ib); sv = is[0];
                    bb = bv ^ {4{sv}};
                    full = {1'b0, av} + {1'b0, bb} + {4'b0, sv};
                    ez = full[3:0];
                    ec = full[4];
                    eo = (av[3] == bb[3]) && (ez[3] != av[3]);
                    a4 = av; b4 = bv; sub4 = sv; iv4 = 1'b1;
                    guard = 0;
                    while (!ir4 && guard < 40) begin
                        or4 = 1'($urandom_range(0, 1));
                        @(posedge clk); #1; guard++;
                    end
                    @(posedge clk); #1;
                    iv4 = 1'b0;
                    a4 = ~av; b4 = ~bv; sub4 = ~sv;
                    guard = 0;
                    while (!ov4 && guard < 40) begin
                        or4 = 1'($urandom_range(0, 1));
                        @(posedge clk); #1; guard++;
                    end
                    gz = z4; gc = cout4; go = ovf4;
                    tests++;
                    if (!ov4 || gz !== ez || gc !== ec || go !== eo) begin
                        fails++;
                        $display("FAIL sweep4 a=%h b=%h sub=%b: got valid=%b z=%h cout=%b ovf=%b, want z=%h cout=%b ovf=%b",
                                 av, bv, sv, ov4, gz, gc, go, ez, ec, eo);
                    end
                    guard = 0;
                    while (ov4 && guard < 40) begin
                        or4 = 1'($urandom_range(0, 1));
                        @(posedge clk); #1; guard++;
                        if (ov4 && (z4 !== gz || cout4 !== gc || ovf4 !== go)) begin
                            tests++;
                            fails++;
                            $display("FAIL sweep4_hold: got z=%h cout=%b ovf=%b, want z=%h cout=%b ovf=%b",
                                     z4, cout4, ovf4, gz, gc, go);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        iv4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0; or4 = 1'b1;
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_exhaustive4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
